// File: rtl/automata_vga_pkg.sv
// Shared timing, cell-grid geometry and fetch FSM type for the automata VGA pixel source.
package automata_vga_pkg;
  localparam logic [10:0] HACTIVE   = 11'd1280;
  localparam logic [10:0] HTOTAL    = 11'd1688;
  localparam logic [10:0] VACTIVE   = 11'd1024;
  localparam logic [10:0] VTOTAL    = 11'd1066;
  localparam logic [10:0] HLAST     = HTOTAL - 11'd1;
  localparam logic [10:0] VLAST     = VTOTAL - 11'd1;
  localparam logic [10:0] VACT_LAST = VACTIVE - 11'd1;

  localparam int CELL_LOG2 = 3;
  localparam int WORD_W    = 32;
  localparam int ADDR_W    = 16;
  localparam int COLS      = int'(HACTIVE) >> CELL_LOG2;
  localparam int ROWS      = int'(VACTIVE) >> CELL_LOG2;
  localparam int WPR       = COLS / WORD_W;
  localparam int COL_W     = $clog2(COLS);
  localparam int ROW_W     = $clog2(ROWS);
  localparam int WIDX_W    = $clog2(WPR);
  localparam int BIT_W     = $clog2(WORD_W);

  localparam logic [23:0] ALIVE_RGB = 24'hFFFF00;
  localparam logic [23:0] DEAD_RGB  = 24'h00BFFF;

  typedef enum logic [1:0] {IDLE, REQ, DONE} fetch_state_t;
endpackage

// File: rtl/automata_line_buffer.sv
// Ping-pong cell-row buffer: one shadow write port, one combinational single-bit read port.
module automata_line_buffer
  import automata_vga_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              swap_i,
  input  logic              wr_en_i,
  input  logic              wr_sel_i,
  input  logic [WIDX_W-1:0] wr_word_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_sel_i,
  input  logic [COL_W-1:0]  rd_col_i,
  output logic              act_o,
  output logic              rd_bit_o
);
  logic [WORD_W-1:0] mem_q [2][WPR];
  logic              act_q;
  logic [WIDX_W-1:0] rd_word;
  logic [BIT_W-1:0]  rd_bit;

  assign rd_word = rd_col_i[COL_W-1:BIT_W];
  assign rd_bit  = rd_col_i[BIT_W-1:0];
  assign act_o   = act_q;

  // Columns past the last word only occur in blanking; return a dead cell there.
  always_comb begin
    rd_bit_o = 1'b0;
    if (int'(rd_word) < WPR) rd_bit_o = mem_q[rd_sel_i][rd_word][rd_bit];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < WPR; w++)
          mem_q[b][w] <= '0;
    end else begin
      if (wr_en_i) mem_q[wr_sel_i][wr_word_i] <= wr_data_i;
      if (swap_i) act_q <= ~act_q;
    end
  end
endmodule

// File: rtl/automata_pixel_fetch.sv
// Turns hcount/vcount into RGB from a cell bitmap; prefetches the next cell row during
// horizontal blanking into the shadow line buffer and swaps buffers at end of line.
module automata_pixel_fetch
  import automata_vga_pkg::*;
(
  input  logic              clk108,
  input  logic              reset_n,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [23:0]       pix_rgb,
  output logic              frame_start,
  output logic              underrun
);
  fetch_state_t      state_q;
  logic              req_q, fs_q, under_q;
  logic [ROW_W-1:0]  row_q;
  logic [WIDX_W-1:0] w_q;
  logic [ADDR_W-1:0] base_q;
  logic [23:0]       pix_q;
  logic              trig_frame, trig_row, eol, swap, wr_en, act, cell_bit;

  assign trig_frame = (hcount == HACTIVE) && (vcount == VLAST);
  assign trig_row   = (hcount == HACTIVE) && (vcount < VACT_LAST) && (&vcount[CELL_LOG2-1:0]);
  assign eol        = (hcount == HLAST);
  assign swap       = eol && (state_q != IDLE);
  // An ack landing on the swap edge belongs to an abandoned fetch; drop it.
  assign wr_en      = (state_q == REQ) && req_q && mem_ack && !eol;

  assign mem_req     = req_q;
  assign mem_addr    = base_q + ADDR_W'(row_q) * ADDR_W'(WPR) + ADDR_W'(w_q);
  assign frame_start = fs_q;
  assign underrun    = under_q;
  assign pix_rgb     = pix_q;

  automata_line_buffer u_lbuf (
    .clk_i     (clk108),
    .rst_ni    (reset_n),
    .swap_i    (swap),
    .wr_en_i   (wr_en),
    .wr_sel_i  (~act),
    .wr_word_i (w_q),
    .wr_data_i (mem_rdata),
    .rd_sel_i  (act),
    .rd_col_i  (hcount[CELL_LOG2 +: COL_W]),
    .act_o     (act),
    .rd_bit_o  (cell_bit)
  );

  always_ff @(posedge clk108 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
      under_q <= 1'b0;
      row_q   <= '0;
      w_q     <= '0;
      base_q  <= '0;
    end else begin
      fs_q <= 1'b0;
      if (swap) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
        if (state_q != DONE) under_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (trig_frame || trig_row) begin
              state_q <= REQ;
              req_q   <= 1'b1;
              w_q     <= '0;
              if (trig_frame) begin
                fs_q   <= 1'b1;
                base_q <= frame_base;
                row_q  <= '0;
              end else begin
                row_q <= vcount[CELL_LOG2 +: ROW_W] + ROW_W'(1);
              end
            end
          end
          REQ: begin
            // Request drops for one cycle between words.
            if (!req_q) begin
              req_q <= 1'b1;
            end else if (mem_ack) begin
              req_q <= 1'b0;
              if (w_q == WIDX_W'(WPR - 1)) state_q <= DONE;
              else w_q <= w_q + WIDX_W'(1);
            end
          end
          DONE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk108 or negedge reset_n) begin
    if (!reset_n) pix_q <= '0;
    else pix_q <= (hcount < HACTIVE && vcount < VACTIVE) ? (cell_bit ? ALIVE_RGB : DEAD_RGB) : 24'h0;
  end
endmodule

// File: tb/tb_automata_pixel_fetch.sv
// Directed bench for automata_pixel_fetch: drives hcount/vcount directly and models the cell memory.
module tb_automata_pixel_fetch;
  logic        clk108 = 1'b0;
  logic        reset_n;
  logic [10:0] hcount, vcount;
  logic [15:0] frame_base;
  logic        mem_req, mem_ack, frame_start, underrun;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [23:0] pix_rgb;

  localparam logic [31:0] ALIVE = 32'h00FF_FF00;
  localparam logic [31:0] DEAD  = 32'h0000_BFFF;

  int checks = 0, failures = 0;
  int lat_sel = 0, lat_cnt = 0;
  int req_cyc = 0, fs_cnt = 0;
  int mark, r0, f0;
  logic [15:0] addr_log[$];

  always #5 clk108 = ~clk108;

  automata_pixel_fetch dut (
    .clk108      (clk108),
    .reset_n     (reset_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_base  (frame_base),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  function automatic logic [31:0] mem_model(input logic [15:0] a);
    case (a)
      16'h0100: return 32'h0000_0001;
      16'h0104: return 32'h8000_0000;
      16'h0105: return 32'h0000_0002;
      16'h0200: return 32'h8000_0000;
      default:  return 32'h0;
    endcase
  endfunction

  assign mem_ack   = mem_req && (lat_cnt >= lat_sel);
  assign mem_rdata = mem_ack ? mem_model(mem_addr) : 32'h0;

  always @(posedge clk108) begin
    lat_cnt <= (mem_req && !mem_ack) ? lat_cnt + 1 : 0;
    if (mem_req) req_cyc <= req_cyc + 1;
    if (mem_req && mem_ack) addr_log.push_back(mem_addr);
    if (frame_start) fs_cnt <= fs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] logged(input int idx);
    if (idx < addr_log.size()) return 32'(addr_log[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic chk_addrs(input string tag, input int m, input logic [15:0] first, input int n);
    chk({tag, "_count"}, 32'(addr_log.size() - m), 32'(n));
    for (int i = 0; i < n; i++) chk(tag, logged(m + i), 32'(first) + 32'(i));
  endtask

  task automatic tick;
    @(posedge clk108);
    #1;
  endtask

  task automatic put(input int v, input int h);
    vcount = 11'(v);
    hcount = 11'(h);
    tick();
  endtask

  task automatic span(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) put(v, h);
  endtask

  initial begin
    reset_n = 1'b0; hcount = '0; vcount = '0; frame_base = 16'h0100;
    repeat (3) tick();
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_pix", 32'(pix_rgb), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_under", 32'(underrun), 0);
    reset_n = 1'b1;
    tick();

    // Frame latch
    mark = addr_log.size(); f0 = fs_cnt;
    put(1065, 1279);
    put(1065, 1280);
    chk("fs_pulse", 32'(frame_start), 1);
    span(1065, 1281, 1687);
    chk("fs_count", 32'(fs_cnt - f0), 1);
    chk_addrs("frame_addr", mark, 16'h0100, 5);
    chk("under_clean", 32'(underrun), 0);
    put(0, 0);    chk("l0_h0", 32'(pix_rgb), ALIVE);
    put(0, 7);    chk("l0_h7", 32'(pix_rgb), ALIVE);
    put(0, 8);    chk("l0_h8", 32'(pix_rgb), DEAD);
    put(0, 1279); chk("l0_h1279", 32'(pix_rgb), ALIVE);

    // Row fetch
    put(7, 0); chk("l7_h0", 32'(pix_rgb), ALIVE);
    put(7, 8); chk("l7_h8", 32'(pix_rgb), DEAD);
    mark = addr_log.size();
    span(7, 1280, 1687);
    chk_addrs("row1_addr", mark, 16'h0105, 5);
    put(8, 0);    chk("l8_h0", 32'(pix_rgb), DEAD);
    put(8, 8);    chk("l8_h8", 32'(pix_rgb), ALIVE);
    put(8, 1279); chk("l8_h1279", 32'(pix_rgb), DEAD);

    // Blanking and last active line
    put(8, 1280);    chk("hblank_pix", 32'(pix_rgb), 0);
    put(1024, 0);    chk("vblank_pix", 32'(pix_rgb), 0);
    put(1065, 8);    chk("vblank2_pix", 32'(pix_rgb), 0);
    mark = addr_log.size(); r0 = req_cyc;
    span(1023, 1279, 1687);
    chk("l1023_req", 32'(req_cyc - r0), 0);
    chk("l1023_addr", 32'(addr_log.size() - mark), 0);

    // Slow memory misses the deadline
    lat_sel = 100;
    mark = addr_log.size();
    span(15, 1280, 1687);
    chk("slow_under", 32'(underrun), 1);
    chk("slow_req_drop", 32'(mem_req), 0);
    chk("slow_first_addr", logged(mark), 32'h010A);
    put(16, 0); put(16, 1);
    chk("slow_sticky", 32'(underrun), 1);
    lat_sel = 0;
    mark = addr_log.size();
    span(23, 1280, 1687);
    chk_addrs("recover_addr", mark, 16'h010F, 5);
    chk("recover_under", 32'(underrun), 1);

    // Tear-free base switch
    put(500, 0);
    frame_base = 16'h0200;
    put(500, 1);
    mark = addr_log.size();
    span(503, 1280, 1687);
    chk_addrs("tear_old_base", mark, 16'h023B, 5);
    mark = addr_log.size();
    span(1065, 1280, 1687);
    chk_addrs("new_base", mark, 16'h0200, 5);
    put(0, 0);   chk("nb_h0", 32'(pix_rgb), DEAD);
    put(0, 247); chk("nb_h247", 32'(pix_rgb), DEAD);
    put(0, 248); chk("nb_h248", 32'(pix_rgb), ALIVE);

    // Reset mid-fetch at word 2
    span(31, 1280, 1284);
    chk("pre_rst_req", 32'(mem_req), 1);
    chk("pre_rst_addr", 32'(mem_addr), 32'h0216);
    reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_pix", 32'(pix_rgb), 0);
    chk("arst_under", 32'(underrun), 0);
    put(31, 1285); put(31, 1286);
    reset_n = 1'b1;
    mark = addr_log.size(); r0 = req_cyc;
    span(31, 1287, 1687);
    chk("post_rst_idle_req", 32'(req_cyc - r0), 0);
    chk("post_rst_idle_addr", 32'(addr_log.size() - mark), 0);
    chk("post_rst_under", 32'(underrun), 0);
    mark = addr_log.size();
    span(39, 1280, 1687);
    chk_addrs("post_rst_fetch", mark, 16'h0019, 5);
    chk("post_rst_under2", 32'(underrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/automata_pixel_fetch.md
Name: automata_pixel_fetch

Overview:
- Pixel source for the 1280x1024 VGA timing generator. It converts the generator's hcount/vcount into 24-bit RGB for each pixel.
- Each automaton cell is drawn as a CELL x CELL pixel square; one bit per cell comes from cell memory.
- During horizontal blanking, the next cell row is prefetched into a ping-pong line buffer through a req/ack memory port. The block sits between the cell-state memory (upstream) and the VGA output (downstream).

Parameters:
- HACTIVE, 1280, active pixels per line
- HTOTAL, 1688, clocks per line
- VACTIVE, 1024, active lines
- VTOTAL, 1066, lines per frame
- CELL_LOG2, 3, log2 of cell edge in pixels (8x8 cells, giving a 160x128 grid)
- WORD_W, 32, cell bits per memory word
- ADDR_W, 16, memory word address width
- ALIVE_RGB, 24'hFFFF00, colour of a live cell
- DEAD_RGB, 24'h00BFFF, colour of a dead cell

Ports:
- clk108  in  1  pixel clock, 108 MHz
- reset_n  in  1  asynchronous, active-low reset
- hcount  in  11  horizontal count from the timing generator
- vcount  in  11  vertical count from the timing generator
- frame_base  in  ADDR_W  word address of the generation to display
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  word address, stable while mem_req=1
- mem_ack  in  1  read accepted; mem_rdata is valid in this cycle
- mem_rdata  in  WORD_W  cell bits; bit k is cell column w*WORD_W+k
- pix_rgb  out  24  {R,G,B} pixel
- frame_start  out  1  one-cycle pulse at the start of each frame fetch
- underrun  out  1  sticky flag: a row fetch missed its deadline

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, both line buffers cleared, active buffer index 0, latched base 0.
- Derived values:
  - COLS = HACTIVE>>CELL_LOG2 = 160
  - WPR (words per row) = COLS/WORD_W = 5
  - crow = vcount>>CELL_LOG2
  - col = hcount>>CELL_LOG2
- Fetch trigger, evaluated when hcount == HACTIVE:
  - If vcount == VTOTAL-1: set frame_start for one cycle, latch frame_base into base_q, and target row 0.
  - Else if vcount < VACTIVE-1 and vcount[CELL_LOG2-1:0] is all ones: target row crow+1.
  - Otherwise no fetch. The last active line (1023) does not trigger.
- FSM states IDLE -> REQ -> DONE:
  - IDLE: on trigger, set w=0 and go to REQ.
  - REQ: drive mem_req=1 and mem_addr = base_q + row*WPR + w, using mod-2^ADDR_W wraparound.
  - On mem_ack in REQ: write mem_rdata into shadow buffer word w. If w == WPR-1, go to DONE; else increment w, drop mem_req for one cycle, then request again.
  - DONE: wait in this state.
- Swap, at endOfLine (hcount == HTOTAL-1) of a triggering line:
  - Toggle the active buffer and return to IDLE.
  - If the FSM is not in DONE at that point: set underrun, drop mem_req, abandon the fetch, and swap anyway. The shadow buffer then holds a mix of new and stale words.
- A trigger while the FSM is not in IDLE cannot occur with legal timing. If it does, it is ignored.
- Pixel path, one cycle of latency:
  - The pixel for hcount=N appears on the clock after hcount=N, aligning with the generator's registered VGA_BLANK_n.
  - pix_rgb <= (hcount < HACTIVE && vcount < VACTIVE) ? (bit ? ALIVE_RGB : DEAD_RGB) : 24'h0.
  - The bit is read from the active buffer at word col/WORD_W, bit col%WORD_W.
- frame_base changes take effect only at the frame latch, so generation switches are tear-free.
- Asynchronous reset mid-fetch deasserts mem_req immediately. Any in-flight ack arriving after reset release while in IDLE is ignored.

Decomposition:
- Package automata_vga_pkg holds:
  - timing constants HACTIVE, HTOTAL, VACTIVE, VTOTAL
  - CELL_LOG2, WORD_W, COLS, WPR
  - fetch_state_t enum {IDLE, REQ, DONE}
- Sub-module automata_line_buffer:
  - 2 x WPR x WORD_W ping-pong register array
  - one write port (buffer select, word index, data)
  - one combinational read port (active select, column) returning a single bit
  - swap input

Test Plan:
- Frame latch: memory returns 32'h1 for word addr base+0 and 0 elsewhere, frame_base=16'h0100, zero-latency ack. Step to vcount=1065, hcount=1280 -> frame_start pulses once and addresses 0x0100..0x0104 are issued in order. On line 0, hcount 0..7 gives pix_rgb=FFFF00 one clock later; hcount 8 gives 00BFFF.
- Row fetch: at vcount=7, hcount=1280 -> addresses 0x0105..0x0109 are fetched; line 8 shows row 1 data, while lines 0-7 still show row 0.
- Blanking: hcount=1280..1687 or vcount>=1024 -> pix_rgb=0. Line 1023 issues no request.
- Slow memory: ack arrives 100 cycles after each request -> the fetch misses endOfLine, underrun=1 and stays set, mem_req drops at the swap, and the next trigger fetches normally.
- Tear-free base: change frame_base to 16'h0200 mid-frame at vcount=500 -> mem_addr values stay in 0x0100 range until the next frame latch, then switch to 0x0200+.
- Reset mid-fetch: reset_n low while mem_req=1 at w=2 -> mem_req=0, pix_rgb=0, underrun=0 immediately. After release, the FSM stays in IDLE until the next trigger.
